// File: rtl/jtag_sync_fifo_pkg.sv
// jtag_types_pkg: shared types and helpers for the JTAG datapath FIFO
package jtag_types_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/jtag_sync_fifo_ptr.sv
// fifo_ptr: wrap-bit pointer register with increment enable and synchronous clear
module fifo_ptr #(
    parameter int PW = 7
) (
    input  logic          TCK,
    input  logic          TRST,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    // clear wins over increment; MSB toggles naturally as the wrap bit
    always_ff @(posedge TCK or negedge TRST)
        if (!TRST)    ptr <= '0;
        else if (clr) ptr <= '0;
        else if (inc) ptr <= ptr + PW'(1);

endmodule

// File: rtl/jtag_sync_fifo.sv
// jtag_sync_fifo: TCK-domain FWFT FIFO with count, watermarks, flush; sticky errors under JTAG_FIFO_ERR_EN
module jtag_sync_fifo
    import jtag_types_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 64,
    parameter int AF_MARGIN = 4,
    parameter int AE_MARGIN = 4
) (
    input  logic                   TCK,
    input  logic                   TRST,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       data_out,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count
`ifdef JTAG_FIFO_ERR_EN
    ,
    output logic                   overflow,
    output logic                   underflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             rd_acc, wr_acc;

    assign empty        = wr_ptr == rd_ptr;
    assign full         = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = count >= PW'(DEPTH - AF_MARGIN);
    assign almost_empty = count <= PW'(AE_MARGIN);
    assign data_out     = mem[rd_ptr[AW-1:0]];

    // a read frees a slot, so a full FIFO still takes a write alongside a read
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    fifo_ptr #(.PW(PW)) u_wr_ptr (
        .TCK  (TCK),
        .TRST (TRST),
        .clr  (flush),
        .inc  (wr_acc),
        .ptr  (wr_ptr)
    );

    fifo_ptr #(.PW(PW)) u_rd_ptr (
        .TCK  (TCK),
        .TRST (TRST),
        .clr  (flush),
        .inc  (rd_acc),
        .ptr  (rd_ptr)
    );

    // storage is never reset; flush and TRST only move the pointers
    always_ff @(posedge TCK)
        if (wr_acc && !flush) mem[wr_ptr[AW-1:0]] <= data_in;

`ifdef JTAG_FIFO_ERR_EN
    // sticky error flags, cleared only by flush or TRST
    always_ff @(posedge TCK or negedge TRST)
        if (!TRST) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full && !rd_acc) overflow  <= 1'b1;
            if (rd_en && empty)           underflow <= 1'b1;
        end
`endif

endmodule
